// File: rtl/sc_shift_master.sv
// sc_shift_master: serial master for the MiniMALTA3 slow-control shift register.
// Latches a SIZE-bit word on an accepted start and shifts it out MSB-first on a
// divided serial clock. While shifting, it captures the register's previous
// contents from the chip, then holds the load strobe for one bit period.
// Optional macro SC_SHIFT_MASTER_VERIFY_EN adds a second shift pass of the same
// word. That pass reads the freshly written contents back and flags a mismatch.
//
// Ports:
//   Clk, rst       system clock, asynchronous active-high reset
//   start          1-cycle request, accepted only while busy=0
//   cfg_data       word to write (latched on accepted start)
//   busy, done     transaction in progress / 1-cycle completion pulse
//   rb_data        previous register contents, updated in the done cycle
//   verify_err     readback mismatch (only with SC_SHIFT_MASTER_VERIFY_EN)
//   sr_clk, sr_data, sr_load   serial clock, data and load strobe to the chip
//   sr_serial_out  chip serial output
module sc_shift_master #(
   parameter int unsigned SIZE = 640,
   parameter int unsigned DIV  = 4
) (
   input  logic            Clk,
   input  logic            rst,
   input  logic            start,
   input  logic [SIZE-1:0] cfg_data,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] rb_data,
   output logic            verify_err,
   output logic            sr_clk,
   output logic            sr_data,
   output logic            sr_load,
   input  logic            sr_serial_out
);

   localparam int unsigned PER   = 2 * DIV;
   localparam int unsigned PH_W  = $clog2(PER);
   localparam int unsigned BIT_W = $clog2(SIZE + 1);

   localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(PER - 1);
   localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(DIV - 1);
   localparam logic [PH_W-1:0]  PH_RISE   = PH_W'(DIV);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_LOAD,
      S_VERIFY,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [PH_W-1:0]   ph_q, ph_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [SIZE-1:0]   tx_q, tx_d;      // outgoing word, MSB is the next bit to send
   logic [SIZE-1:0]   sh_q, sh_d;      // readback shift register
   logic [SIZE-1:0]   rb_q, rb_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              sr_clk_q, sr_clk_d;
   logic              sr_data_q, sr_data_d;
   logic              sr_load_q, sr_load_d;
   logic              ph_last;
   logic [PH_W-1:0]   ph_nxt;

`ifdef SC_SHIFT_MASTER_VERIFY_EN
   logic [SIZE-1:0]   word_q, word_d;   // latched word, reused by the verify pass
   logic [SIZE-1:0]   first_q, first_d; // first-pass readback kept for rb_data
   logic              verr_q, verr_d;
`endif

   // Sequencing, counters and registered outputs
   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      sh_d      = sh_q;
      rb_d      = rb_q;
      sr_data_d = sr_data_q;
`ifdef SC_SHIFT_MASTER_VERIFY_EN
      word_d    = word_q;
      first_d   = first_q;
      verr_d    = verr_q;
`endif
      ph_last = (ph_q == PH_LAST);
      ph_nxt  = ph_last ? '0 : ph_q + PH_W'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_SHIFT;
               ph_d      = '0;
               bit_d     = '0;
               tx_d      = cfg_data;
               sr_data_d = cfg_data[SIZE-1];
`ifdef SC_SHIFT_MASTER_VERIFY_EN
               word_d    = cfg_data;
               verr_d    = 1'b0;
`endif
            end
         end

`ifdef SC_SHIFT_MASTER_VERIFY_EN
         S_SHIFT, S_VERIFY: begin
`else
         S_SHIFT: begin
`endif
            ph_d = ph_nxt;
            // Sample one Clk before the rising edge, before the chip shifts
            if (ph_q == PH_SAMPLE) begin
               sh_d = {sh_q[SIZE-2:0], sr_serial_out};
            end
            if (ph_last) begin
               if (bit_q == BIT_LAST) begin
                  bit_d     = '0;
                  sr_data_d = 1'b0;
`ifdef SC_SHIFT_MASTER_VERIFY_EN
                  if (state_q == S_VERIFY) begin
                     state_d = S_DONE;
                     rb_d    = first_q;
                     verr_d  = (sh_q != word_q);
                  end else begin
                     state_d = S_LOAD;
                  end
`else
                  state_d = S_LOAD;
`endif
               end else begin
                  bit_d     = bit_q + BIT_W'(1);
                  tx_d      = {tx_q[SIZE-2:0], 1'b0};
                  sr_data_d = tx_q[SIZE-2];
               end
            end
         end

         S_LOAD: begin
            ph_d      = ph_nxt;
            sr_data_d = 1'b0;
            if (ph_last) begin
`ifdef SC_SHIFT_MASTER_VERIFY_EN
               state_d   = S_VERIFY;
               first_d   = sh_q;
               tx_d      = word_q;
               sr_data_d = word_q[SIZE-1];
               bit_d     = '0;
`else
               state_d = S_DONE;
               rb_d    = sh_q;
`endif
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      sr_load_d = (state_d == S_LOAD);
      // ph returns to 0 whenever the shifter idles, so sr_clk rests low
      sr_clk_d  = (ph_d >= PH_RISE);
   end

   // State register
   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ph_q      <= '0;
         bit_q     <= '0;
         tx_q      <= '0;
         sh_q      <= '0;
         rb_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sr_clk_q  <= 1'b0;
         sr_data_q <= 1'b0;
         sr_load_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         bit_q     <= bit_d;
         tx_q      <= tx_d;
         sh_q      <= sh_d;
         rb_q      <= rb_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sr_clk_q  <= sr_clk_d;
         sr_data_q <= sr_data_d;
         sr_load_q <= sr_load_d;
      end
   end

`ifdef SC_SHIFT_MASTER_VERIFY_EN
   // Verify-pass state
   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         word_q  <= '0;
         first_q <= '0;
         verr_q  <= 1'b0;
      end else begin
         word_q  <= word_d;
         first_q <= first_d;
         verr_q  <= verr_d;
      end
   end

   assign verify_err = verr_q;
`else
   assign verify_err = 1'b0;
`endif

   assign busy    = busy_q;
   assign done    = done_q;
   assign rb_data = rb_q;
   assign sr_clk  = sr_clk_q;
   assign sr_data = sr_data_q;
   assign sr_load = sr_load_q;

endmodule
